// File: rtl/rv32_mem_port_arbiter.sv
// Three-way arbiter sharing one synchronous memory port, with starvation promotion
// for fetch/DMA and a LATENCY-deep in-flight tracker that routes read data back.
module rv32_mem_port_arbiter #(
   parameter int LATENCY      = 2,
   parameter int STARVE_LIMIT = 8
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [2:0]  req_valid_i,
   output logic [2:0]  req_ready_o,
   input  logic [11:0] req_we_i,
   input  logic [95:0] req_addr_i,
   input  logic [95:0] req_wdata_i,
   input  logic [2:0]  flush_i,
   output logic [2:0]  rsp_valid_o,
   output logic [31:0] rsp_rdata_o,
   output logic        mem_en_o,
   output logic [3:0]  mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   input  logic [31:0] mem_rdata_i
);

   localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

   typedef struct packed {
      logic       live;
      logic [1:0] id;
   } ent_t;

   ent_t        r_pipe [LATENCY];
   logic [7:0]  r_wait [1:2];

   logic        w_starve1, w_starve2;
   logic [2:0]  w_grant;
   logic [1:0]  w_id;
   logic [3:0]  w_we;
   logic [31:0] w_addr, w_wdata;
   ent_t        w_out;

   function automatic ent_t flush_ent(input ent_t e, input logic [2:0] f);
      logic [3:0] fx;
      fx = {1'b0, f};
      flush_ent = e;
      if (fx[e.id]) flush_ent.live = 1'b0;
   endfunction

   assign w_starve1 = req_valid_i[1] && (r_wait[1] >= LIMIT);
   assign w_starve2 = req_valid_i[2] && (r_wait[2] >= LIMIT);

   // Starved requesters outrank everyone; DMA wins a tie between two starved ones.
   always_comb begin
      w_grant = 3'b000;
      if (rst_i)               w_grant = 3'b000;
      else if (w_starve2)      w_grant = 3'b100;
      else if (w_starve1)      w_grant = 3'b010;
      else if (req_valid_i[0]) w_grant = 3'b001;
      else if (req_valid_i[1]) w_grant = 3'b010;
      else if (req_valid_i[2]) w_grant = 3'b100;
   end

   assign w_id    = w_grant[2] ? 2'd2 : (w_grant[1] ? 2'd1 : 2'd0);
   assign w_we    = req_we_i[{w_id, 2'b00} +: 4];
   assign w_addr  = req_addr_i[{w_id, 5'b00000} +: 32];
   assign w_wdata = req_wdata_i[{w_id, 5'b00000} +: 32];

   assign req_ready_o = w_grant;
   assign mem_en_o    = |w_grant;
   assign mem_we_o    = mem_en_o ? w_we    : 4'b0;
   assign mem_addr_o  = mem_en_o ? w_addr  : 32'b0;
   assign mem_wdata_o = mem_en_o ? w_wdata : 32'b0;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_wait[1] <= 8'd0;
         r_wait[2] <= 8'd0;
      end else begin
         for (int n = 1; n < 3; n++) begin
            if (!req_valid_i[n] || w_grant[n]) r_wait[n] <= 8'd0;
            else if (r_wait[n] < LIMIT)        r_wait[n] <= r_wait[n] + 8'd1;
         end
      end
   end

   // New entry enters unflushed; stored entries are flushed as they shift.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < LATENCY; i++) r_pipe[i] <= '0;
      end else begin
         r_pipe[0] <= '{live: mem_en_o && (w_we == 4'b0), id: w_id};
         for (int i = 1; i < LATENCY; i++) r_pipe[i] <= flush_ent(r_pipe[i-1], flush_i);
      end
   end

   assign w_out       = flush_ent(r_pipe[LATENCY-1], flush_i);
   assign rsp_valid_o = (w_out.live && !rst_i) ? (3'b001 << w_out.id) : 3'b000;
   assign rsp_rdata_o = (|rsp_valid_o) ? mem_rdata_i : 32'b0;

endmodule

// File: tb/tb_rv32_mem_port_arbiter.sv
// Directed self-checking bench for rv32_mem_port_arbiter with an in-order memory model.
module tb_rv32_mem_port_arbiter;

   localparam int LAT = 2;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic [2:0]  req_valid_i;
   logic [2:0]  req_ready_o;
   logic [11:0] req_we_i;
   logic [95:0] req_addr_i;
   logic [95:0] req_wdata_i;
   logic [2:0]  flush_i;
   logic [2:0]  rsp_valid_o;
   logic [31:0] rsp_rdata_o;
   logic        mem_en_o;
   logic [3:0]  mem_we_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wdata_o;
   logic [31:0] mem_rdata_i;

   int tests = 0;
   int fails = 0;

   rv32_mem_port_arbiter #(.LATENCY(LAT), .STARVE_LIMIT(8)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .req_we_i(req_we_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
      .flush_i(flush_i), .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o),
      .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
      .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
   );

   always #5 clk_i = ~clk_i;

   // Memory model: read data = ~addr, except 0x100 which returns 0xDEADBEEF.
   logic [31:0] md [LAT];
   function automatic logic [31:0] rdfn(input logic [31:0] a);
      return (a == 32'h100) ? 32'hDEADBEEF : ~a;
   endfunction
   always @(posedge clk_i) begin
      md[0] <= rdfn(mem_addr_o);
      for (int k = 1; k < LAT; k++) md[k] <= md[k-1];
   end
   assign mem_rdata_i = md[LAT-1];

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle();
      req_valid_i = 3'b0; req_we_i = '0; req_addr_i = '0; req_wdata_i = '0; flush_i = 3'b0;
   endtask

   task automatic set_req(input int n, input logic [3:0] we, input logic [31:0] addr,
                          input logic [31:0] wdata);
      req_we_i[4*n +: 4]     = we;
      req_addr_i[32*n +: 32]  = addr;
      req_wdata_i[32*n +: 32] = wdata;
   endtask

   task automatic drain();
      idle();
      repeat (4) tick();
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      idle();
      req_valid_i = 3'b111;
      set_req(0, 4'b1111, 32'hAAAA_0000, 32'h5555_5555);
      set_req(1, 4'b0000, 32'h100, 32'h0);
      tick(); tick(); #1;
      tests++;
      if (req_ready_o !== 3'b0 || mem_en_o !== 1'b0) begin
         fails++; $display("FAIL reset_grant ready=%b en=%b want 000/0", req_ready_o, mem_en_o);
      end
      tests++;
      if (mem_we_o !== 4'b0 || mem_addr_o !== 32'b0 || mem_wdata_o !== 32'b0) begin
         fails++; $display("FAIL reset_mem we=%h addr=%h wdata=%h want 0", mem_we_o, mem_addr_o, mem_wdata_o);
      end
      tests++;
      if (rsp_valid_o !== 3'b0 || rsp_rdata_o !== 32'b0) begin
         fails++; $display("FAIL reset_rsp valid=%b rdata=%h want 0", rsp_valid_o, rsp_rdata_o);
      end
      idle();
      tick();
      rst_i = 1'b0;
      drain();
   endtask

   task automatic test_read_latency();
      tick();
      set_req(1, 4'b0000, 32'h100, 32'h0);
      req_valid_i = 3'b010;
      #1;
      tests++;
      if (req_ready_o !== 3'b010 || mem_en_o !== 1'b1 || mem_addr_o !== 32'h100 || mem_we_o !== 4'b0) begin
         fails++; $display("FAIL read_issue ready=%b en=%b addr=%h we=%b want 010/1/100/0000",
                           req_ready_o, mem_en_o, mem_addr_o, mem_we_o);
      end
      tick();
      idle();
      #1;
      tests++;
      if (rsp_valid_o !== 3'b0) begin
         fails++; $display("FAIL read_early valid=%b want 000", rsp_valid_o);
      end
      tick(); #1;
      tests++;
      if (rsp_valid_o !== 3'b010 || rsp_rdata_o !== 32'hDEADBEEF) begin
         fails++; $display("FAIL read_rsp valid=%b rdata=%h want 010/deadbeef", rsp_valid_o, rsp_rdata_o);
      end
      tick(); #1;
      tests++;
      if (rsp_valid_o !== 3'b0) begin
         fails++; $display("FAIL read_late valid=%b want 000", rsp_valid_o);
      end
      drain();
   endtask

   task automatic test_starve();
      logic [2:0] exp;
      for (int c = 0; c <= 10; c++) begin
         tick();
         if (c == 0) begin
            set_req(0, 4'b0000, 32'h10, 32'h0);
            set_req(1, 4'b0000, 32'h20, 32'h0);
            set_req(2, 4'b0000, 32'h30, 32'h0);
            req_valid_i = 3'b111;
         end
         #1;
         exp = (c < 8) ? 3'b001 : (c == 8) ? 3'b100 : (c == 9) ? 3'b010 : 3'b001;
         tests++;
         if (req_ready_o !== exp) begin
            fails++; $display("FAIL starve_c%0d ready=%b want %b", c, req_ready_o, exp);
         end
      end
      drain();
   endtask

   task automatic test_flush();
      tick();
      set_req(1, 4'b0000, 32'h100, 32'h0);
      req_valid_i = 3'b010;
      tick();
      set_req(1, 4'b0000, 32'h104, 32'h0);
      flush_i = 3'b010;
      #1;
      tests++;
      if (req_ready_o !== 3'b010) begin
         fails++; $display("FAIL flush_regrant ready=%b want 010", req_ready_o);
      end
      tick();
      idle();
      #1;
      tests++;
      if (rsp_valid_o !== 3'b0) begin
         fails++; $display("FAIL flush_drop valid=%b want 000", rsp_valid_o);
      end
      tick(); #1;
      tests++;
      if (rsp_valid_o !== 3'b010 || rsp_rdata_o !== 32'hFFFF_FEFB) begin
         fails++; $display("FAIL flush_same_cycle_grant valid=%b rdata=%h want 010/fffffefb", rsp_valid_o, rsp_rdata_o);
      end
      drain();
      // Output-stage suppression for id 0 while id 2 is left alone.
      tick();
      set_req(0, 4'b0000, 32'h10, 32'h0);
      req_valid_i = 3'b001;
      tick();
      set_req(2, 4'b0000, 32'h30, 32'h0);
      req_valid_i = 3'b100;
      tick();
      idle();
      flush_i = 3'b001;
      #1;
      tests++;
      if (rsp_valid_o !== 3'b0) begin
         fails++; $display("FAIL flush_output_stage valid=%b want 000", rsp_valid_o);
      end
      tick();
      flush_i = 3'b0;
      #1;
      tests++;
      if (rsp_valid_o !== 3'b100 || rsp_rdata_o !== 32'hFFFF_FFCF) begin
         fails++; $display("FAIL flush_isolation valid=%b rdata=%h want 100/ffffffcf", rsp_valid_o, rsp_rdata_o);
      end
      drain();
   endtask

   task automatic test_write();
      tick();
      set_req(0, 4'b0011, 32'h1000_0004, 32'h1234_5678);
      req_valid_i = 3'b001;
      #1;
      tests++;
      if (req_ready_o !== 3'b001 || mem_we_o !== 4'b0011 || mem_addr_o !== 32'h1000_0004 ||
          mem_wdata_o !== 32'h1234_5678) begin
         fails++; $display("FAIL write_issue ready=%b we=%b addr=%h wdata=%h want 001/0011/10000004/12345678",
                           req_ready_o, mem_we_o, mem_addr_o, mem_wdata_o);
      end
      for (int c = 0; c < 4; c++) begin
         tick();
         idle();
         #1;
         tests++;
         if (rsp_valid_o !== 3'b0) begin
            fails++; $display("FAIL write_no_rsp_c%0d valid=%b want 000", c, rsp_valid_o);
         end
      end
   endtask

   task automatic test_async_reset();
      tick();
      set_req(0, 4'b0000, 32'h200, 32'h0);
      req_valid_i = 3'b001;
      tick();
      set_req(1, 4'b0000, 32'h204, 32'h0);
      req_valid_i = 3'b010;
      #3;
      rst_i = 1'b1;
      #1;
      tests++;
      if (req_ready_o !== 3'b0 || mem_en_o !== 1'b0 || mem_addr_o !== 32'b0 || rsp_valid_o !== 3'b0) begin
         fails++; $display("FAIL async_reset ready=%b en=%b addr=%h rsp=%b want all 0",
                           req_ready_o, mem_en_o, mem_addr_o, rsp_valid_o);
      end
      idle();
      @(posedge clk_i);
      #3;
      rst_i = 1'b0;
      for (int c = 0; c < 4; c++) begin
         tick();
         tests++;
         if (rsp_valid_o !== 3'b0) begin
            fails++; $display("FAIL async_reset_lost_c%0d valid=%b want 000", c, rsp_valid_o);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [2:0]  exp_v;
      logic [31:0] exp_d;
      for (int c = 0; c < 6; c++) begin
         tick();
         idle();
         case (c)
            0: begin set_req(0, 4'b0, 32'h10, 32'h0); req_valid_i = 3'b001; end
            1: begin set_req(1, 4'b0, 32'h20, 32'h0); req_valid_i = 3'b010; end
            2: begin set_req(2, 4'b0, 32'h30, 32'h0); req_valid_i = 3'b100; end
            3: begin set_req(0, 4'b0, 32'h40, 32'h0); req_valid_i = 3'b001; end
            default: ;
         endcase
         #1;
         if (c < 4) begin
            tests++;
            if (req_ready_o !== req_valid_i || mem_en_o !== 1'b1) begin
               fails++; $display("FAIL b2b_issue_c%0d ready=%b en=%b want %b/1", c, req_ready_o, mem_en_o, req_valid_i);
            end
         end
         if (c >= 2) begin
            case (c)
               2: begin exp_v = 3'b001; exp_d = 32'hFFFF_FFEF; end
               3: begin exp_v = 3'b010; exp_d = 32'hFFFF_FFDF; end
               4: begin exp_v = 3'b100; exp_d = 32'hFFFF_FFCF; end
               default: begin exp_v = 3'b001; exp_d = 32'hFFFF_FFBF; end
            endcase
            tests++;
            if (rsp_valid_o !== exp_v || rsp_rdata_o !== exp_d) begin
               fails++; $display("FAIL b2b_rsp_c%0d valid=%b rdata=%h want %b/%h", c, rsp_valid_o, rsp_rdata_o, exp_v, exp_d);
            end
         end
      end
      drain();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      idle();
      test_reset();
      test_read_latency();
      test_starve();
      test_flush();
      test_write();
      test_async_reset();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
